// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: multi-limb add/subtract built on a shared DataWidth-bit ALU.
// One limb is processed per cycle, least-significant limb first. The carry is
// chained through the ALU carry-in flag. Subtract is performed as A + ~B + 1.
module alu_wide_sequencer #(
    parameter int         DataWidth = 16,
    parameter int         Limbs     = 2,
    parameter int         FlagBits  = 4,
    parameter logic [3:0] AddOp     = 4'h0,
    parameter logic [3:0] SubOp     = 4'h1
) (
    input  logic                         Clk,
    input  logic                         Reset_N,
    input  logic                         Start,
    input  logic [3:0]                   FuncOp,
    input  logic                         CarryIn,
    input  logic [Limbs*DataWidth-1:0]   OpA,
    input  logic [Limbs*DataWidth-1:0]   OpB,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Err,
    output logic [Limbs*DataWidth-1:0]   Result,
    output logic [FlagBits-1:0]          OFlags,
    output logic [DataWidth-1:0]         AluA,
    output logic [DataWidth-1:0]         AluB,
    output logic [3:0]                   AluOp,
    output logic [FlagBits-1:0]          AluIFlags,
    input  logic [DataWidth-1:0]         AluY,
    input  logic [FlagBits-1:0]          AluOFlags
);

    localparam int WideW = Limbs * DataWidth;
    localparam int IdxW  = $clog2(Limbs);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Limbs - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    // Flag bit positions {V,N,C,Z}
    localparam int FlagZ = 0;
    localparam int FlagC = 1;
    localparam int FlagN = 2;
    localparam int FlagV = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IdxW-1:0]    idx_q;
    logic [WideW-1:0]   a_q;
    logic [WideW-1:0]   b_q;
    logic               sub_q;
    logic               carry_q;
    logic               zacc_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [WideW-1:0]   result_q;
    logic [FlagBits-1:0] oflags_q;

    logic               op_valid_s;
    logic               carry_seed_d;
    logic [DataWidth-1:0] limb_a_s;
    logic [DataWidth-1:0] limb_b_s;
    logic [FlagBits-1:0] final_flags_d;

    // Decode the requested operation and its carry seed (subtract seeds the +1).
    always_comb begin
        op_valid_s   = (FuncOp == AddOp) || (FuncOp == SubOp);
        carry_seed_d = (FuncOp == SubOp) ? 1'b1 : CarryIn;
    end

    // Select the current limb of each captured operand; B is inverted for subtract.
    always_comb begin
        limb_a_s = a_q[idx_q*DataWidth +: DataWidth];
        if (sub_q) begin
            limb_b_s = ~b_q[idx_q*DataWidth +: DataWidth];
        end else begin
            limb_b_s = b_q[idx_q*DataWidth +: DataWidth];
        end
    end

    // Assemble the wide flags from the top-limb ALU result and the zero accumulator.
    always_comb begin
        final_flags_d        = {FlagBits{1'b0}};
        final_flags_d[FlagV] = AluOFlags[FlagV];
        final_flags_d[FlagN] = AluY[DataWidth-1];
        final_flags_d[FlagC] = AluOFlags[FlagC];
        final_flags_d[FlagZ] = zacc_q & AluOFlags[FlagZ];
    end

    // Drive the ALU: limb operands only in RUN, op fixed to add.
    always_comb begin
        AluOp     = AddOp;
        AluA      = {DataWidth{1'b0}};
        AluB      = {DataWidth{1'b0}};
        AluIFlags = {FlagBits{1'b0}};
        if (state_q == ST_RUN) begin
            AluA             = limb_a_s;
            AluB             = limb_b_s;
            AluIFlags[FlagC] = carry_q;
        end else begin
            AluIFlags = {FlagBits{1'b0}};
        end
    end

    // Sequencer FSM with operand capture, limb write-back and registered status.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IdxW{1'b0}};
            a_q      <= {WideW{1'b0}};
            b_q      <= {WideW{1'b0}};
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= {WideW{1'b0}};
            oflags_q <= {FlagBits{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        busy_q <= 1'b1;
                        idx_q  <= {IdxW{1'b0}};
                        if (op_valid_s) begin
                            a_q     <= OpA;
                            b_q     <= OpB;
                            sub_q   <= (FuncOp == SubOp);
                            carry_q <= carry_seed_d;
                            zacc_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= ST_RUN;
                        end else begin
                            result_q <= {WideW{1'b0}};
                            oflags_q <= {FlagBits{1'b0}};
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result_q[idx_q*DataWidth +: DataWidth] <= AluY;
                    carry_q <= AluOFlags[FlagC];
                    zacc_q  <= zacc_q & AluOFlags[FlagZ];
                    if (idx_q == LastIdx) begin
                        oflags_q <= final_flags_d;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IdxOne;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= {IdxW{1'b0}};
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Err    = err_q;
    assign Result = result_q;
    assign OFlags = oflags_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Testbench for alu_wide_sequencer: behavioural ALU and wide-arithmetic model,
// per-cycle comparison, directed corner cases with literal expectations and
// randomized operations.
module tb_alu_wide_sequencer;

    localparam int DW = 16;
    localparam int L  = 2;
    localparam int FB = 4;
    localparam int W  = DW * L;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;

    logic          Clk = 1'b0;
    logic          Reset_N = 1'b0;
    logic          Start = 1'b0;
    logic [3:0]    FuncOp = OP_ADD;
    logic          CarryIn = 1'b0;
    logic [W-1:0]  OpA = '0;
    logic [W-1:0]  OpB = '0;
    logic          Busy, Done, Err;
    logic [W-1:0]  Result;
    logic [FB-1:0] OFlags;
    logic [DW-1:0] AluA, AluB;
    logic [3:0]    AluOp;
    logic [FB-1:0] AluIFlags;
    logic [DW-1:0] AluY;
    logic [FB-1:0] AluOFlags;

    int n_checks = 0;
    int n_fail   = 0;

    alu_wide_sequencer #(
        .DataWidth(DW), .Limbs(L), .FlagBits(FB), .AddOp(OP_ADD), .SubOp(OP_SUB)
    ) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Start(Start), .FuncOp(FuncOp),
        .CarryIn(CarryIn), .OpA(OpA), .OpB(OpB), .Busy(Busy), .Done(Done),
        .Err(Err), .Result(Result), .OFlags(OFlags), .AluA(AluA), .AluB(AluB),
        .AluOp(AluOp), .AluIFlags(AluIFlags), .AluY(AluY), .AluOFlags(AluOFlags)
    );

    always #5 Clk = ~Clk;

    // ALU model: add with carry-in, flags {V,N,C,Z}
    always_comb begin
        logic [DW:0] s;
        s = {1'b0, AluA} + {1'b0, AluB} + {{DW{1'b0}}, AluIFlags[1]};
        AluY = s[DW-1:0];
        AluOFlags = '0;
        AluOFlags[0] = (s[DW-1:0] == '0);
        AluOFlags[1] = s[DW];
        AluOFlags[2] = s[DW-1];
        AluOFlags[3] = (AluA[DW-1] == AluB[DW-1]) && (s[DW-1] != AluA[DW-1]);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int           cyc = 0;
    int           m_start = 0;
    int           m_done_at = -1;
    bit           m_busy = 1'b0;
    bit           p_err = 1'b0;
    bit           p_sub = 1'b0;
    bit           p_cin = 1'b0;
    logic [W-1:0] p_a = '0, p_bx = '0, p_res = '0, m_res = '0;
    logic [3:0]   p_flags = '0, m_flags = '0;

    // Model update at each rising edge, then compare outputs 1 time unit later
    initial forever begin
        logic [W:0]  sum, part, lowmask;
        logic        v, exp_done, in_run;
        int          idx;
        @(posedge Clk);
        cyc++;
        if (!Reset_N) begin
            m_busy = 1'b0; m_done_at = -1; m_res = '0; m_flags = '0; p_err = 1'b0;
        end else if (m_busy && cyc == m_done_at + 1) begin
            m_busy = 1'b0;
        end else if (!m_busy && Start) begin
            p_err = !(FuncOp == OP_ADD || FuncOp == OP_SUB);
            p_sub = (FuncOp == OP_SUB);
            p_a   = OpA;
            p_bx  = p_sub ? ~OpB : OpB;
            p_cin = p_sub ? 1'b1 : CarryIn;
            if (p_err) begin
                p_res = '0; p_flags = '0;
            end else begin
                sum   = {1'b0, p_a} + {1'b0, p_bx} + (W+1)'(p_cin);
                p_res = sum[W-1:0];
                if (p_sub) v = (OpA[W-1] != OpB[W-1]) && (p_res[W-1] != OpA[W-1]);
                else       v = (OpA[W-1] == OpB[W-1]) && (p_res[W-1] != OpA[W-1]);
                p_flags = {v, p_res[W-1], sum[W], (p_res == '0)};
            end
            m_busy = 1'b1;
            m_start = cyc;
            m_done_at = cyc + (p_err ? 0 : L);
        end
        if (m_busy && cyc == m_done_at) begin
            m_res = p_res; m_flags = p_flags;
        end
        #1;
        exp_done = m_busy && (cyc == m_done_at);
        in_run   = m_busy && !p_err && (cyc < m_done_at);
        check("busy", Busy, m_busy);
        check("done", Done, exp_done);
        check("err", Err, exp_done && p_err);
        check("aluop", AluOp, OP_ADD);
        if (!in_run) begin
            check("result", Result, m_res);
            check("oflags", OFlags, m_flags);
            check("alu_a_idle", AluA, '0);
            check("alu_b_idle", AluB, '0);
            check("alu_if_idle", AluIFlags, '0);
        end else begin
            idx = cyc - m_start;
            lowmask = ((W+1)'(1) << (idx*DW)) - (W+1)'(1);
            part = ({1'b0, p_a} & lowmask) + ({1'b0, p_bx} & lowmask) + (W+1)'(p_cin);
            check("alu_a_limb", AluA, p_a[idx*DW +: DW]);
            check("alu_b_limb", AluB, p_bx[idx*DW +: DW]);
            check("alu_carry_in", AluIFlags, {2'b00, part[idx*DW], 1'b0});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: Busy=1 after 50 cycles, required 0");
        end
    endtask

    task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input bit lit,
                         input logic [W-1:0] er, input logic [3:0] ef, input logic ee);
        int n;
        bit seen;
        wait_idle();
        @(negedge Clk);
        FuncOp = op; OpA = a; OpB = b; CarryIn = cin; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        OpA = $urandom; OpB = $urandom; FuncOp = 4'($urandom); CarryIn = 1'($urandom);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            if (Done) seen = 1'b1;
            else begin
                @(negedge Clk);
                n++;
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: Done not seen in 20 cycles", nm);
        end else if (lit) begin
            check({nm, " latency"}, n, ee ? 0 : L);
            check({nm, " result"}, Result, er);
            check({nm, " flags"}, OFlags, ef);
            check({nm, " err"}, Err, ee);
        end
        @(negedge Clk);
    endtask

    initial begin
        int cnt;
        logic [W-1:0] corner [5];
        logic [W-1:0] ra, rb;
        logic [3:0] rop;
        int r;
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h0000_FFFF;

        repeat (3) @(negedge Clk);
        Reset_N = 1'b1;
        check("reset result", Result, '0);
        check("reset flags", OFlags, '0);
        check("reset busy", Busy, 1'b0);

        do_op("add1",  OP_ADD, 32'h0001_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0002_0000, 4'b0000, 1'b0);
        do_op("add2",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 4'b0011, 1'b0);
        do_op("addc",  OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0001, 4'b0000, 1'b0);
        do_op("sub1",  OP_SUB, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_FFFF, 4'b0010, 1'b0);
        do_op("sub2",  OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0100, 1'b0);
        do_op("addv",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 4'b1100, 1'b0);
        do_op("subv",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b1010, 1'b0);
        do_op("err",   4'hF,   32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0000, 4'b0000, 1'b1);

        // Start held through RUN and DONE: exactly one Done
        wait_idle();
        @(negedge Clk);
        FuncOp = OP_ADD; OpA = 32'h0000_0005; OpB = 32'h0000_0007; CarryIn = 1'b0; Start = 1'b1;
        cnt = 0;
        for (int i = 0; i < L + 2; i++) begin
            @(negedge Clk);
            if (Done) cnt++;
        end
        Start = 1'b0;
        check("held start done count", cnt, 1);
        check("held start result", Result, 32'h0000_000C);
        repeat (3) @(negedge Clk);

        // Reset during the first RUN cycle aborts with no Done
        wait_idle();
        @(negedge Clk);
        FuncOp = OP_ADD; OpA = 32'h0001_0001; OpB = 32'h0002_0002; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Reset_N = 1'b0;
        @(negedge Clk);
        Reset_N = 1'b1;
        check("abort busy", Busy, 1'b0);
        check("abort done", Done, 1'b0);
        check("abort result", Result, '0);
        repeat (4) @(negedge Clk);

        // Randomized operations
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      rop = 4'($urandom_range(2, 15));
            else if (r < 5)  rop = OP_ADD;
            else             rop = OP_SUB;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            do_op("rand", rop, ra, rb, 1'($urandom), 1'b0, '0, '0, 1'b0);
        end

        repeat (5) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
